pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It owns the enable and flush strobes of the four pipeline latches and the PC enable, resolving load-use hazards that forwarding cannot cover, instruction/data cache waits, branch/jump redirects and halt. It sits beside the forwarding unit: forwarding handles ALU-to-ALU and MEM-to-ALU bypass, and this block inserts the bubbles forwarding cannot remove. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access in MEM completed this cycle.
- mem_dreq  in  1  EX/MEM latch holds a load or store.
- id_rs1, id_rs2  in  5 each  source registers decoded in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- idex_memread  in  1  ID/EX latch holds a load.
- idex_rd  in  5  load destination in ID/EX.
- mem_redirect  in  1  taken branch or jump resolved in MEM.
- wb_halt  in  1  halt instruction is in MEM/WB.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous bubble insert, qualified by that latch's enable.
- halt  out  1  sticky halt to the system.
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not HALTED.
- flush_cnt  out  CNT_W  redirect events taken.

## Operation
States:
- RUN
- DWAIT (data access outstanding)
- HALTED

State transitions:
- Any state, wb_halt=1, not in DWAIT -> HALTED. Absorbing; only RST exits.
- RUN, mem_dreq & !dhit -> DWAIT.
- DWAIT -> RUN on the first cycle with dhit=1.

Output priority within RUN, highest first:
- **Data wait** (mem_dreq & !dhit). All enables 0, all flushes 0.
- **Redirect** (mem_redirect, gated on ihit):
  - ihit=1: all enables 1, ifid_flush=1, idex_flush=1, exmem_flush=1, flush_cnt+1.
  - ihit=0: pc_en=0 and ifid_en=0. The back end freezes so that mem_redirect persists until fetch completes.
- **Load-use**: idex_memread & idex_rd≠0 & (idex_rd==id_rs1 | (id_uses_rs2 & idex_rd==id_rs2)). Outputs:
  - pc_en=0, ifid_en=0
  - idex_en=1 with idex_flush=1
  - exmem_en=1, memwb_en=1
- **I-miss** (!ihit). pc_en=0. ifid_en=1 with ifid_flush=1. All other enables 1.
- **Otherwise** all enables 1, all flushes 0.

Other states:
- DWAIT: outputs identical to the data-wait case. On the dhit=1 cycle, memwb_en=1 and exmem_en=1. The rest of the priority list is then evaluated with the data-wait term removed.
- HALTED: all enables 0, all flushes 0, halt=1.
- Counters saturate at all-ones and do not wrap.

## Timing
- Outputs are combinational from state and current inputs (Mealy), with zero-cycle latency. Latches sample the strobes on the same CLK edge.
- Load-use costs exactly one bubble. The next cycle the load is in MEM and forwarding takes over.
- Redirect costs 3 squashed slots.
- halt asserts combinationally in the cycle wb_halt=1 and is registered sticky from the following edge.
- Reset (async, any cycle, including mid-DWAIT):
  - State becomes RUN, counters become 0, halt=0.
  - While RST=1, all enables and flushes are 0.
- Simultaneous events:
  - wb_halt with DWAIT: finish the access first, then HALTED.
  - Redirect with load-use: redirect wins, and the flushed ID instruction needs no stall.
- idex_rd=0 never triggers a stall.

## Structure
- hazard_state_t enum and CNT_W default go in cpu_types_pkg, next to regbits_t and word_t.
- One sub-module, load_use_detect: the combinational comparator on rs1/rs2/rd/memread. It is reused by the debug tracer.
- The top holds the FSM, the priority mux and the counters.

## Test plan
- **Load-use.** lw x5 in ID/EX, add x6,x5,x7 in ID, ihit=dhit=1. Required: pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1.
- **Data miss.** mem_dreq=1, dhit=0 for 4 cycles then 1. Required: DWAIT for 4 cycles, all enables 0; dhit cycle has memwb_en=1; stall_cnt=4.
- **Redirect with I-miss.**
  - Cycle 1: mem_redirect=1, ihit=0. Required: pc_en=0, no flush.
  - Cycle 2: ihit=1. Required: three flushes asserted, flush_cnt=1.
- **Halt during data miss.** wb_halt=1 during DWAIT. Required: HALTED entered after dhit; halt stays 1 for 10 further cycles regardless of inputs.
- **Reset mid-DWAIT.** Assert RST asynchronously. Required: all outputs 0 immediately; after release, state is RUN and counters are 0.
- **Saturation.** Bench with CNT_W=4, force 20 stall cycles. Required: stall_cnt holds at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word widths, hazard FSM states
// and the pipeline latch control bundle.
package cpu_types_pkg;

   localparam int XLEN      = 32;
   localparam int CNT_W_DEF = 32;

   typedef logic [4:0]      regbits_t;
   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DWAIT,
      ST_HALTED
   } hazard_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
   } hazard_ctl_t;

   localparam hazard_ctl_t CTL_STOP = 8'b0000_0000;
   localparam hazard_ctl_t CTL_RUN  = 8'b1111_1000;
   localparam hazard_ctl_t CTL_SQSH = 8'b1111_1111;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in ID/EX whose rd is read by
// the instruction in ID. x0 never creates a dependency.
module load_use_detect
   import cpu_types_pkg::*;
(
   input  logic     idex_memread,
   input  regbits_t idex_rd,
   input  regbits_t id_rs1,
   input  regbits_t id_rs2,
   input  logic     id_uses_rs2,
   output logic     stall
);

   logic hit_rs1;
   logic hit_rs2;

   assign hit_rs1 = (idex_rd == id_rs1);
   assign hit_rs2 = id_uses_rs2 & (idex_rd == id_rs2);
   assign stall   = idex_memread & (idex_rd != '0)
                  & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: FSM,
// priority mux over hazards, saturating perf counters.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dreq,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic             mem_redirect,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hazard_state_t    state_q, state_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   hazard_ctl_t ctl;
   logic        lu_stall;
   logic        run_eval;
   logic        halt_now;
   logic        redir_take;
   logic        stall_inc;

   load_use_detect u_lud (
      .idex_memread (idex_memread),
      .idex_rd      (idex_rd),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs2  (id_uses_rs2),
      .stall        (lu_stall)
   );

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      run_eval   = 1'b0;
      halt_now   = 1'b0;
      redir_take = 1'b0;
      ctl        = CTL_STOP;

      unique case (state_q)
         ST_RUN: begin
            if (mem_dreq & ~dhit) begin
               state_d = ST_DWAIT;
               pend_d  = wb_halt;
            end else begin
               run_eval = 1'b1;
               if (wb_halt) begin
                  state_d  = ST_HALTED;
                  halt_now = 1'b1;
               end
            end
         end
         ST_DWAIT: begin
            pend_d = pend_q | wb_halt;
            if (dhit) begin
               run_eval = 1'b1;
               pend_d   = 1'b0;
               if (wb_halt | pend_q) begin
                  state_d  = ST_HALTED;
                  halt_now = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Redirect beats load-use: the dependent ID op is squashed.
      if (run_eval) begin
         if (mem_redirect) begin
            if (ihit) begin
               ctl        = CTL_SQSH;
               redir_take = 1'b1;
            end else begin
               ctl = CTL_STOP;
            end
         end else if (lu_stall) begin
            ctl            = CTL_STOP;
            ctl.idex_en    = 1'b1;
            ctl.idex_flush = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
         end else if (~ihit) begin
            ctl            = CTL_RUN;
            ctl.pc_en      = 1'b0;
            ctl.ifid_flush = 1'b1;
         end else begin
            ctl = CTL_RUN;
         end
      end
   end

   assign stall_inc = (state_q != ST_HALTED) & ~ctl.pc_en;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (stall_inc && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
      if (redir_take && (flush_q != '1))
         flush_d = flush_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_RUN;
         pend_q  <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign pc_en       = ctl.pc_en       & ~RST;
   assign ifid_en     = ctl.ifid_en     & ~RST;
   assign idex_en     = ctl.idex_en     & ~RST;
   assign exmem_en    = ctl.exmem_en    & ~RST;
   assign memwb_en    = ctl.memwb_en    & ~RST;
   assign ifid_flush  = ctl.ifid_flush  & ~RST;
   assign idex_flush  = ctl.idex_flush  & ~RST;
   assign exmem_flush = ctl.exmem_flush & ~RST;

   assign halt      = ((state_q == ST_HALTED) | halt_now) & ~RST;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, 4-bit counters so
// saturation is reachable.
module tb_pipeline_hazard_ctrl;

   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          ihit, dhit, mem_dreq;
   logic [4:0]    id_rs1, id_rs2, idex_rd;
   logic          id_uses_rs2, idex_memread;
   logic          mem_redirect, wb_halt;
   logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic          ifid_flush, idex_flush, exmem_flush, halt;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [7:0]    obs;

   int n_run  = 0;
   int n_fail = 0;

   localparam logic [7:0] C_STOP = 8'b00000_000;
   localparam logic [7:0] C_RUN  = 8'b11111_000;
   localparam logic [7:0] C_LU   = 8'b00111_010;
   localparam logic [7:0] C_IMIS = 8'b01111_100;
   localparam logic [7:0] C_SQSH = 8'b11111_111;

   pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ihit         (ihit),
      .dhit         (dhit),
      .mem_dreq     (mem_dreq),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs2  (id_uses_rs2),
      .idex_memread (idex_memread),
      .idex_rd      (idex_rd),
      .mem_redirect (mem_redirect),
      .wb_halt      (wb_halt),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .memwb_en     (memwb_en),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .exmem_flush  (exmem_flush),
      .halt         (halt),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush};

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic idle();
      ihit         = 1'b1;
      dhit         = 1'b1;
      mem_dreq     = 1'b0;
      id_rs1       = 5'd0;
      id_rs2       = 5'd0;
      id_uses_rs2  = 1'b0;
      idex_memread = 1'b0;
      idex_rd      = 5'd0;
      mem_redirect = 1'b0;
      wb_halt      = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      RST = 1'b1;
      #1;
      RST = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle();
      #2;
      n_run++;
      if (obs !== C_STOP || halt !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_out: ctl=%b halt=%b want %b/0",
                  obs, halt, C_STOP);
      end
      tick();
      n_run++;
      if (obs !== C_STOP || stall_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_hold: ctl=%b stall=%0d want %b/0",
                  obs, stall_cnt, C_STOP);
      end
      RST = 1'b0;
      #1;
      n_run++;
      if (obs !== C_RUN) begin
         n_fail++;
         $display("FAIL rst_rel: ctl=%b want %b", obs, C_RUN);
      end
      tick();
      n_run++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_cnt: stall=%0d flush=%0d want 0/0",
                  stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      idex_memread = 1'b1;
      idex_rd      = 5'd0;
      id_rs1       = 5'd0;
      #1;
      n_run++;
      if (obs !== C_RUN) begin
         n_fail++;
         $display("FAIL lu_x0: ctl=%b want %b", obs, C_RUN);
      end
      idex_rd     = 5'd7;
      id_rs1      = 5'd1;
      id_rs2      = 5'd7;
      id_uses_rs2 = 1'b0;
      #1;
      n_run++;
      if (obs !== C_RUN) begin
         n_fail++;
         $display("FAIL lu_rs2_unused: ctl=%b want %b", obs, C_RUN);
      end
      id_uses_rs2 = 1'b1;
      #1;
      n_run++;
      if (obs !== C_LU) begin
         n_fail++;
         $display("FAIL lu_rs2: ctl=%b want %b", obs, C_LU);
      end
      idex_rd = 5'd5;
      id_rs1  = 5'd5;
      id_rs2  = 5'd7;
      #1;
      n_run++;
      if (obs !== C_LU) begin
         n_fail++;
         $display("FAIL lu_rs1: ctl=%b want %b", obs, C_LU);
      end
      tick();
      idex_memread = 1'b0;
      #1;
      n_run++;
      if (obs !== C_RUN || stall_cnt !== 4'd1) begin
         n_fail++;
         $display("FAIL lu_after: ctl=%b stall=%0d want %b/1",
                  obs, stall_cnt, C_RUN);
      end
   endtask

   task automatic test_data_miss();
      do_reset();
      mem_dreq = 1'b1;
      dhit     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_run++;
         if (obs !== C_STOP || stall_cnt !== 4'(i)) begin
            n_fail++;
            $display("FAIL dmiss_%0d: ctl=%b stall=%0d want %b/%0d",
                     i, obs, stall_cnt, C_STOP, i);
         end
         tick();
      end
      dhit = 1'b1;
      #1;
      n_run++;
      if (obs !== C_RUN) begin
         n_fail++;
         $display("FAIL dmiss_hit: ctl=%b want %b", obs, C_RUN);
      end
      tick();
      mem_dreq = 1'b0;
      dhit     = 1'b0;
      #1;
      n_run++;
      if (obs !== C_RUN || stall_cnt !== 4'd4) begin
         n_fail++;
         $display("FAIL dmiss_end: ctl=%b stall=%0d want %b/4",
                  obs, stall_cnt, C_RUN);
      end
   endtask

   task automatic test_dwait_imiss();
      do_reset();
      mem_dreq = 1'b1;
      dhit     = 1'b0;
      tick();
      dhit = 1'b1;
      ihit = 1'b0;
      #1;
      n_run++;
      if (obs !== C_IMIS) begin
         n_fail++;
         $display("FAIL dwait_imiss: ctl=%b want %b", obs, C_IMIS);
      end
      tick();
      idle();
      #1;
      n_run++;
      if (obs !== C_RUN || stall_cnt !== 4'd2) begin
         n_fail++;
         $display("FAIL dwait_imiss_end: ctl=%b stall=%0d want %b/2",
                  obs, stall_cnt, C_RUN);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      ihit = 1'b0;
      #1;
      n_run++;
      if (obs !== C_IMIS) begin
         n_fail++;
         $display("FAIL imiss: ctl=%b want %b", obs, C_IMIS);
      end
      mem_redirect = 1'b1;
      #1;
      n_run++;
      if (obs !== C_STOP) begin
         n_fail++;
         $display("FAIL redir_wait: ctl=%b want %b", obs, C_STOP);
      end
      tick();
      ihit = 1'b1;
      idex_memread = 1'b1;
      idex_rd      = 5'd9;
      id_rs1       = 5'd9;
      #1;
      n_run++;
      if (obs !== C_SQSH || flush_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL redir_take: ctl=%b flush=%0d want %b/0",
                  obs, flush_cnt, C_SQSH);
      end
      tick();
      idle();
      #1;
      n_run++;
      if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
         n_fail++;
         $display("FAIL redir_cnt: flush=%0d stall=%0d want 1/1",
                  flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_halt_run();
      do_reset();
      wb_halt = 1'b1;
      #1;
      n_run++;
      if (halt !== 1'b1 || obs !== C_RUN) begin
         n_fail++;
         $display("FAIL halt_comb: halt=%b ctl=%b want 1/%b",
                  halt, obs, C_RUN);
      end
      tick();
      wb_halt = 1'b0;
      #1;
      n_run++;
      if (halt !== 1'b1 || obs !== C_STOP) begin
         n_fail++;
         $display("FAIL halt_sticky: halt=%b ctl=%b want 1/%b",
                  halt, obs, C_STOP);
      end
   endtask

   task automatic test_halt_dmiss();
      do_reset();
      mem_dreq = 1'b1;
      dhit     = 1'b0;
      tick();
      wb_halt = 1'b1;
      #1;
      n_run++;
      if (halt !== 1'b0 || obs !== C_STOP) begin
         n_fail++;
         $display("FAIL hd_wait: halt=%b ctl=%b want 0/%b",
                  halt, obs, C_STOP);
      end
      tick();
      wb_halt = 1'b0;
      tick();
      dhit = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         {ihit, dhit, mem_dreq, mem_redirect, wb_halt,
          idex_memread} = 6'($urandom);
         id_rs1  = 5'($urandom);
         idex_rd = id_rs1;
         #1;
         n_run++;
         if (halt !== 1'b1 || obs !== C_STOP
             || stall_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL hd_halted_%0d: halt=%b ctl=%b stall=%0d want 1/%b/3",
                     i, halt, obs, stall_cnt, C_STOP);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_dwait();
      do_reset();
      mem_dreq = 1'b1;
      dhit     = 1'b0;
      tick();
      tick();
      n_run++;
      if (stall_cnt !== 4'd2) begin
         n_fail++;
         $display("FAIL rmd_pre: stall=%0d want 2", stall_cnt);
      end
      #1;
      RST = 1'b1;
      #1;
      idle();
      #1;
      n_run++;
      if (obs !== C_STOP || halt !== 1'b0
          || stall_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL rmd_async: ctl=%b halt=%b stall=%0d want %b/0/0",
                  obs, halt, stall_cnt, C_STOP);
      end
      RST  = 1'b0;
      dhit = 1'b0;
      #1;
      n_run++;
      if (obs !== C_RUN || stall_cnt !== 4'd0
          || flush_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL rmd_run: ctl=%b stall=%0d flush=%0d want %b/0/0",
                  obs, stall_cnt, flush_cnt, C_RUN);
      end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      ihit = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         #1;
         n_run++;
         if (stall_cnt !== 4'((i > 15) ? 15 : i)) begin
            n_fail++;
            $display("FAIL sat_stall_%0d: stall=%0d want %0d",
                     i, stall_cnt, (i > 15) ? 15 : i);
         end
         tick();
      end
      idle();
      mem_redirect = 1'b1;
      for (int i = 0; i <= 18; i++) begin
         #1;
         n_run++;
         if (flush_cnt !== 4'((i > 15) ? 15 : i)) begin
            n_fail++;
            $display("FAIL sat_flush_%0d: flush=%0d want %0d",
                     i, flush_cnt, (i > 15) ? 15 : i);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_data_miss();
      test_dwait_imiss();
      test_redirect();
      test_halt_run();
      test_halt_dmiss();
      test_reset_mid_dwait();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
